// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction read port, data read/write port) onto one
// shared memory port, with alternating priority on conflict and a response timeout.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [DATA_WIDTH-1:0] i_read_data,
  output logic                  i_response,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [DATA_WIDTH-1:0] d_write_data,
  output logic [DATA_WIDTH-1:0] d_read_data,
  output logic                  d_response,
  output logic                  m_read,
  output logic                  m_write,
  output logic [ADDR_WIDTH-1:0] m_address,
  output logic [DATA_WIDTH-1:0] m_write_data,
  input  logic [DATA_WIDTH-1:0] m_read_data,
  input  logic                  m_response,
  output logic                  err
);

  // state | meaning
  // IDLE  | no transaction; arbitrate between requesters
  // BUSY  | m_* driven for the granted port, waiting for m_response or timeout
  // RESP  | one-cycle response pulse to the granted port

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state;
  logic          grant_d;
  logic          last_grant_d;
  logic [CW-1:0] count;
  logic          req_i;
  logic          req_d;
  logic          pick_d;

  assign req_i  = i_read;
  assign req_d  = d_read | d_write;
  // On conflict, the port not granted last time wins
  assign pick_d = req_d & (~req_i | ~last_grant_d);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      grant_d      <= 1'b0;
      last_grant_d <= 1'b1;
      count        <= '0;
      m_read       <= 1'b0;
      m_write      <= 1'b0;
      m_address    <= '0;
      m_write_data <= '0;
      i_read_data  <= '0;
      d_read_data  <= '0;
      i_response   <= 1'b0;
      d_response   <= 1'b0;
      err          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          i_response <= 1'b0;
          d_response <= 1'b0;
          err        <= 1'b0;
          if (req_i || req_d) begin
            grant_d      <= pick_d;
            last_grant_d <= pick_d;
            count        <= '0;
            state        <= BUSY;
            if (pick_d) begin
              m_address    <= d_address;
              m_write_data <= d_write_data;
              m_write      <= d_write;
              m_read       <= ~d_write;
            end else begin
              m_address    <= i_address;
              m_write_data <= '0;
              m_write      <= 1'b0;
              m_read       <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (m_response) begin
            m_read  <= 1'b0;
            m_write <= 1'b0;
            if (m_read) begin
              if (grant_d) d_read_data <= m_read_data;
              else         i_read_data <= m_read_data;
            end
            if (grant_d) d_response <= 1'b1;
            else         i_response <= 1'b1;
            state <= RESP;
          end else if (count == CNT_LAST) begin
            m_read  <= 1'b0;
            m_write <= 1'b0;
            if (grant_d) d_read_data <= {DATA_WIDTH{1'b1}};
            else         i_read_data <= {DATA_WIDTH{1'b1}};
            if (grant_d) d_response <= 1'b1;
            else         i_response <= 1'b1;
            err   <= 1'b1;
            state <= RESP;
          end else begin
            count <= count + 1'b1;
          end
        end
        RESP: begin
          i_response <= 1'b0;
          d_response <= 1'b0;
          err        <= 1'b0;
          count      <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width of all ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width of all ports.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, maximum cycles to wait for m_response.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports i_read (in, 1), i_address (in, ADDR_WIDTH), i_read_data (out, DATA_WIDTH) and i_response (out, 1): the core instruction port, read-only.
REQ-007 SHALL have ports d_read (in, 1), d_write (in, 1), d_address (in, ADDR_WIDTH), d_write_data (in, DATA_WIDTH), d_read_data (out, DATA_WIDTH) and d_response (out, 1): the core data port.
REQ-008 SHALL have ports m_read (out, 1), m_write (out, 1), m_address (out, ADDR_WIDTH), m_write_data (out, DATA_WIDTH), m_read_data (in, DATA_WIDTH) and m_response (in, 1): the single shared memory port toward the controller.
REQ-009 SHALL have port err  output  1  one-cycle pulse flagging a timed-out transaction.

Function
REQ-010 SHALL follow this requester protocol: request held high with address/data stable until the matching response pulse; response is a one-cycle pulse.
REQ-011 SHALL implement FSM states IDLE, BUSY and RESP; arbitration occurs only in IDLE.
REQ-012 SHALL, in IDLE with exactly one requester active, grant it, register its address/data/direction onto the m_* outputs and enter BUSY; m_read/m_write go high the cycle after the request is sampled.
REQ-013 SHALL, in IDLE with both requesters active, grant the one not granted most recently; last_grant resets to "data", so instruction wins the first conflict.
REQ-014 SHALL treat d_read and d_write both high as a write.
REQ-015 SHALL hold m_read/m_write/m_address/m_write_data constant throughout BUSY.
REQ-016 SHALL, in BUSY on m_response=1, drop m_read/m_write next cycle, capture m_read_data into the granted port's read_data register (reads only; writes leave d_read_data unchanged) and enter RESP.
REQ-017 SHALL, in RESP, pulse the granted port's response for exactly that one cycle, then return to IDLE without sampling requests during RESP.
REQ-018 SHALL give a latency, request sampled in cycle 0 with memory answering in cycle k>=1, of m_read/m_write high at cycle 1 and requester response at cycle k+1; minimum 2 cycles.
REQ-019 SHALL count BUSY cycles from 0; if the count reaches TIMEOUT_CYCLES-1 without m_response, drop m_read/m_write, load read_data with all-ones, pulse err together with the requester response in RESP, and return to IDLE.
REQ-020 SHALL ignore m_response in IDLE or RESP: no state change and no output change.
REQ-021 SHALL keep the non-granted port's response low and its read_data unchanged.
REQ-022 SHALL never assert m_read and m_write simultaneously, nor both i_response and d_response in the same cycle.

Reset
REQ-023 SHALL, on reset low and regardless of clk, immediately force FSM=IDLE, last_grant=data, timeout counter=0, and all outputs (m_*, i_read_data, d_read_data, i_response, d_response, err) to 0.
REQ-024 SHALL abandon an in-flight transaction on reset, with no response pulse afterward; a late m_response after reset release is ignored per REQ-020.
REQ-025 SHALL treat reset release as synchronous to clk, with the first arbitration on the first rising edge after release.

Verification
REQ-026 SHALL verify a single instruction read: i_read=1, i_address=0x100, memory answers 0x00000013 after 3 cycles -> m_read high cycles 1-3, i_read_data=0x00000013 and i_response at cycle 4.
REQ-027 SHALL verify a data write: d_write=1, d_address=0x2000, d_write_data=0xCAFEBABE, m_response at cycle 1 -> m_write=1 with those values at cycle 1, d_response at cycle 2, d_read_data unchanged.
REQ-028 SHALL verify a conflict after reset: i_read and d_read both high and held -> instruction served first, then data, then instruction alternately; no back-to-back grant to the same port while both are active.
REQ-029 SHALL verify timeout with TIMEOUT_CYCLES=8 and no m_response -> m_read drops after 8 BUSY cycles, d_response, err and d_read_data=0xFFFFFFFF occur in the same cycle.
REQ-030 SHALL verify reset mid-BUSY: reset low at cycle 2 of a read -> all outputs 0 immediately; m_response pulsed after release -> no response pulse.
REQ-031 SHALL verify a stray m_response in IDLE -> no outputs change.
